// File: rtl/fa_bist_checker.sv
// fa_bist_checker: built-in self test sequencer for a single full adder.
// Sweeps all eight {A,B,Cin} vectors PASSES times, holding each vector for
// SETTLE_CYC cycles before sampling S/Co for one cycle. Mismatches are
// counted into a saturating 4-bit error counter.
// Optional feature: define FA_BIST_ERRLOG_EN to add first_err_vec and
// first_err_valid, which record the vector of the first mismatch in a run.
module fa_bist_checker #(
    parameter int SETTLE_CYC = 1,   // 1..15
    parameter int PASSES     = 1    // 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A_f,
    output logic       B_f,
    output logic       Cin_f,
    input  logic       S_f,
    input  logic       Co_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] vec_idx
`ifdef FA_BIST_ERRLOG_EN
    ,
    output logic [2:0] first_err_vec,
    output logic       first_err_valid
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;           // doubles as the registered stimulus
    logic [3:0] settle_q, settle_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;
`ifdef FA_BIST_ERRLOG_EN
    logic [2:0] fe_vec_q, fe_vec_d;
    logic       fe_valid_q, fe_valid_d;
`endif

    // Golden full-adder response for the vector currently applied
    logic exp_s;
    logic exp_co;
    logic mismatch;

    assign exp_s    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    assign exp_co   = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    assign mismatch = (S_f != exp_s) || (Co_f != exp_co);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            settle_q   <= '0;
            pass_cnt_q <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            pass_cnt_q <= pass_cnt_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
        end
    end

`ifdef FA_BIST_ERRLOG_EN
    // First-error log registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_vec_q   <= '0;
            fe_valid_q <= 1'b0;
        end else begin
            fe_vec_q   <= fe_vec_d;
            fe_valid_q <= fe_valid_d;
        end
    end
`endif

    // Next-state logic: sequencing, error counting and verdict
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        pass_cnt_d = pass_cnt_q;
        err_d      = err_q;
        pass_d     = pass_q;
`ifdef FA_BIST_ERRLOG_EN
        fe_vec_d   = fe_vec_q;
        fe_valid_d = fe_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = '0;
                    settle_d   = '0;
                    pass_cnt_d = '0;
                    err_d      = '0;
                    pass_d     = 1'b0;
`ifdef FA_BIST_ERRLOG_EN
                    fe_vec_d   = '0;
                    fe_valid_d = 1'b0;
`endif
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != 4'hF) begin
                        err_d = err_q + 4'd1;
                    end
`ifdef FA_BIST_ERRLOG_EN
                    if (!fe_valid_q) begin
                        fe_vec_d   = vec_q;
                        fe_valid_d = 1'b1;
                    end
`endif
                end
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    state_d = ST_DRIVE;
                end else if (pass_cnt_q != PASS_LAST) begin
                    vec_d      = '0;
                    pass_cnt_d = pass_cnt_q + 4'd1;
                    state_d    = ST_DRIVE;
                end else begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == 4'd0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign A_f     = vec_q[2];
    assign B_f     = vec_q[1];
    assign Cin_f   = vec_q[0];
    assign vec_idx = vec_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;
    assign busy    = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done    = (state_q == ST_DONE);
`ifdef FA_BIST_ERRLOG_EN
    assign first_err_vec   = fe_vec_q;
    assign first_err_valid = fe_valid_q;
`endif

endmodule
